instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer.sv | 114 +++++++++++
 tb/tb_instr_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Bundle of the run/fetch/unit signals for instr_sequencer; the sequencer uses the slave
// modport and the driving side uses master. dbg_state mirrors the FSM state register.
interface instr_sequencer_if;
  logic       run;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] unit_done;
  logic       fetch_req;
  logic [3:0] unit_start;
  logic [2:0] src_sel;
  logic [2:0] dst_sel;
  logic       busy;
  logic       halted;
  logic [7:0] instr_count;
  logic       timeout_err;
  logic [2:0] dbg_state;

  modport slave (
    input  run, instr, instr_valid, unit_done,
    output fetch_req, unit_start, src_sel, dst_sel, busy, halted,
           instr_count, timeout_err, dbg_state
  );

  modport master (
    output run, instr, instr_valid, unit_done,
    input  fetch_req, unit_start, src_sel, dst_sel, busy, halted,
           instr_count, timeout_err, dbg_state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue/wait/retire sequencer driving four execution units.
// Optional WAIT watchdog enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RETIRE = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_instr;
  logic [2:0] r_src_sel;
  logic [2:0] r_dst_sel;
  logic [7:0] r_instr_count;
  logic       r_fetch_req;
  logic [3:0] r_unit_start;
  logic       r_busy;
  logic       r_halted;
  logic [1:0] w_op;
  logic [3:0] w_start_onehot;
  logic       w_done;
  logic       w_wd_expire;

  assign w_op           = r_instr[7:6];
  assign w_start_onehot = 4'b0001 << w_op;
  // Only the issued unit's done bit matters; the others are don't-care.
  assign w_done         = bus.unit_done[w_op];

`ifdef SEQ_WATCHDOG_EN
  logic [3:0] r_wd_cnt;
  logic       r_timeout_err;

  // Expires at the end of the 15th WAIT cycle without a matching done.
  assign w_wd_expire = (r_state == S_WAIT) && !w_done && (r_wd_cnt == 4'd14);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt      <= 4'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wd_cnt <= 4'd0;
      else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + 4'd1;
      if (w_wd_expire)            r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_wd_expire     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.run) w_next = S_FETCH;
      S_FETCH:  if (bus.instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = (r_instr == 8'hFF) ? S_HALT : S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_done)           w_next = S_RETIRE;
        else if (w_wd_expire) w_next = S_IDLE;
      end
      S_RETIRE: w_next = bus.run ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_instr       <= 8'd0;
      r_src_sel     <= 3'd0;
      r_dst_sel     <= 3'd0;
      r_instr_count <= 8'd0;
      r_fetch_req   <= 1'b0;
      r_unit_start  <= 4'd0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.instr_valid) r_instr <= bus.instr;
      if (r_state == S_DECODE && r_instr != 8'hFF) begin
        r_src_sel <= r_instr[5:3];
        r_dst_sel <= r_instr[2:0];
      end
      if (r_state == S_RETIRE) r_instr_count <= r_instr_count + 8'd1;
      r_fetch_req  <= (w_next == S_FETCH);
      r_unit_start <= (w_next == S_ISSUE) ? w_start_onehot : 4'd0;
      r_busy       <= !(w_next == S_IDLE || w_next == S_HALT);
      r_halted     <= (w_next == S_HALT);
    end
  end

  assign bus.fetch_req   = r_fetch_req;
  assign bus.unit_start  = r_unit_start;
  assign bus.src_sel     = r_src_sel;
  assign bus.dst_sel     = r_dst_sel;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.instr_count = r_instr_count;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer; expected unit_start pulses are
// queued in exp_q and matched by a negedge monitor, the retire count is modelled mod 256.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic reset;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_count = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Every nonzero unit_start sample must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.unit_start !== 4'b0000) begin
      if (exp_q.size() == 0) check("unexpected_start", {28'd0, bus.unit_start}, 32'd0);
      else                   check("start_order", {28'd0, bus.unit_start}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (bus.fetch_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("fetch_req_seen", {31'd0, bus.fetch_req}, 32'd1);
  endtask

  // Presents one non-halt instruction and checks the start pulse; returns in WAIT cycle 1.
  task automatic issue_instr(input logic [7:0] ins);
    logic [3:0] own;
    own = 4'b0001 << ins[7:6];
    wait_fetch();
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    exp_q.push_back(own);
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = 8'($urandom);
    step();
    check("unit_start", {28'd0, bus.unit_start}, {28'd0, own});
    check("src_sel", {29'd0, bus.src_sel}, {29'd0, ins[5:3]});
    check("dst_sel", {29'd0, bus.dst_sel}, {29'd0, ins[2:0]});
    check("busy_issue", {31'd0, bus.busy}, 32'd1);
    step();
    check("start_one_cycle", {28'd0, bus.unit_start}, 32'd0);
  endtask

  task automatic finish_instr(input logic [7:0] ins, input int dly, input logic [3:0] noise,
                              input bit drop_run);
    logic [3:0] own;
    own = 4'b0001 << ins[7:6];
    if (drop_run) bus.run = 1'b0;
    for (int k = 0; k < dly; k++) begin
      bus.unit_done = noise & ~own;
      step();
      check("wait_busy", {31'd0, bus.busy}, 32'd1);
      check("wait_count", {24'd0, bus.instr_count}, exp_count);
    end
    bus.unit_done = own | (noise & ~own);
    step();
    bus.unit_done = 4'd0;
    check("retire_src_hold", {29'd0, bus.src_sel}, {29'd0, ins[5:3]});
    exp_count = (exp_count + 1) % 256;
    step();
    check("instr_count", {24'd0, bus.instr_count}, exp_count);
    check("fetch_after_retire", {31'd0, bus.fetch_req}, {31'd0, bus.run});
    check("busy_after_retire", {31'd0, bus.busy}, {31'd0, bus.run});
  endtask

  task automatic exec_instr(input logic [7:0] ins, input int dly, input logic [3:0] noise,
                            input bit drop_run);
    issue_instr(ins);
    finish_instr(ins, dly, noise, drop_run);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    exp_count = 0;
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ins;
    reset           = 1'b1;
    bus.run         = 1'b0;
    bus.instr       = 8'd0;
    bus.instr_valid = 1'b0;
    bus.unit_done   = 4'd0;
    step();
    check("rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    check("rst_unit_start", {28'd0, bus.unit_start}, 32'd0);
    check("rst_src_sel", {29'd0, bus.src_sel}, 32'd0);
    check("rst_dst_sel", {29'd0, bus.dst_sel}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_count", {24'd0, bus.instr_count}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
    reset   = 1'b0;
    bus.run = 1'b1;

    // MOV r1->r2, done two cycles after the start pulse.
    exec_instr(8'h0A, 1, 4'd0, 1'b0);
    // ADD, SUB, JMP with immediate done.
    exec_instr(8'h4B, 0, 4'd0, 1'b0);
    exec_instr(8'h9C, 0, 4'd0, 1'b0);
    exec_instr(8'hC0, 0, 4'd0, 1'b0);
    // ADD with MOV done held high until ADD done arrives.
    exec_instr(8'h5A, 3, 4'b0001, 1'b0);

    // Random traffic long enough to wrap the retire counter.
    for (int i = 0; i < 260; i++) begin
      ins = 8'($urandom);
      if (ins == 8'hFF) ins = 8'hFE;
      exec_instr(ins, $urandom_range(0, 3), 4'($urandom), 1'b0);
    end

    // run dropped during WAIT: instruction completes, then IDLE.
    exec_instr(8'h53, 2, 4'($urandom), 1'b1);
    repeat (3) step();
    check("idle_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in WAIT drops outputs at once; a later done is ignored in IDLE.
    bus.run = 1'b1;
    issue_instr(8'h11);
    #2 reset = 1'b1;
    #1;
    check("async_unit_start", {28'd0, bus.unit_start}, 32'd0);
    check("async_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    check("async_busy", {31'd0, bus.busy}, 32'd0);
    check("async_count", {24'd0, bus.instr_count}, 32'd0);
    exp_count = 0;
    step();
    reset         = 1'b0;
    bus.run       = 1'b0;
    bus.unit_done = 4'b0001;
    repeat (3) step();
    bus.unit_done = 4'd0;
    check("done_in_idle_count", {24'd0, bus.instr_count}, 32'd0);
    check("done_in_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Unit that never completes.
    bus.run = 1'b1;
    issue_instr(8'h8E);
`ifdef SEQ_WATCHDOG_EN
    repeat (14) step();
    check("wd_pre_timeout", {31'd0, bus.timeout_err}, 32'd0);
    check("wd_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.run = 1'b0;
    step();
    check("wd_timeout", {31'd0, bus.timeout_err}, 32'd1);
    check("wd_busy", {31'd0, bus.busy}, 32'd0);
    check("wd_count", {24'd0, bus.instr_count}, exp_count);
    repeat (4) step();
    check("wd_sticky", {31'd0, bus.timeout_err}, 32'd1);
`else
    repeat (99) step();
    check("nowd_busy", {31'd0, bus.busy}, 32'd1);
    check("nowd_timeout", {31'd0, bus.timeout_err}, 32'd0);
    check("nowd_count", {24'd0, bus.instr_count}, exp_count);
`endif
    do_reset();

    // HALT is absorbing until reset.
    bus.run = 1'b1;
    wait_fetch();
    bus.instr       = 8'hFF;
    bus.instr_valid = 1'b1;
    step();
    step();
    check("halted", {31'd0, bus.halted}, 32'd1);
    check("halt_busy", {31'd0, bus.busy}, 32'd0);
    check("halt_unit_start", {28'd0, bus.unit_start}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.instr     = 8'($urandom);
      bus.unit_done = 4'($urandom);
      step();
      check("halt_hold", {31'd0, bus.halted}, 32'd1);
      check("halt_hold_fetch", {31'd0, bus.fetch_req}, 32'd0);
      check("halt_hold_count", {24'd0, bus.instr_count}, 32'd0);
    end
    bus.instr_valid = 1'b0;
    bus.unit_done   = 4'd0;
    reset = 1'b1;
    #1;
    check("reset_clears_halt", {31'd0, bus.halted}, 32'd0);
    step();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
